// File: rtl/sp_ram_pkg.sv
// Shared constants, FSM state type and parity helper for the sp_ram_be buffer.
package sp_ram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Even-parity bit for one lane; callers zero-extend the lane to 64 bits.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sp_ram_init_seq.sv
// INIT/READY control FSM and the address counter that sweeps INIT_VALUE into
// every RAM location after reset.
module sp_ram_init_seq
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_init_addr,
  output logic                  o_init_we
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;

  // The all-ones write is the last one; the counter is never used again
  // until the next reset, so it is allowed to roll over.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (&r_cnt) r_state <= ST_READY;
    end
  end

  assign o_busy      = (r_state == ST_INIT);
  assign o_init_we   = (r_state == ST_INIT);
  assign o_init_addr = r_cnt;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte-lane write enables, selectable read-during-write
// mode and a post-reset init sweep. Optional lane parity: `define SP_RAM_PARITY_EN.
module sp_ram_be
  import sp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    WRITE_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             par_err
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || WRITE_MODE > 2 || BYTE_WIDTH > 64) begin : g_param_check
      $error("sp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and WRITE_MODE <= 2");
    end
  endgenerate

  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_init_we;

  sp_ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_busy      (w_busy),
    .o_init_addr (w_init_addr),
    .o_init_we   (w_init_we)
  );

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_par_err;

  logic                  w_acc;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [NB-1:0]         w_lane_we;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_old_err;
  logic                  w_new_err;

  // The sweep owns the single port while busy; user inputs are dropped.
  assign w_acc     = ~w_busy & en;
  assign w_wr      = w_init_we | (w_acc & we);
  assign w_addr    = w_busy ? w_init_addr : addr;
  assign w_lane_we = w_busy ? {NB{1'b1}} : be;
  assign w_wdata   = w_busy ? INIT_VALUE : din;
  assign w_old     = r_mem[w_addr];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (w_lane_we[i]) w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_addr] <= w_merged;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_old_par;
  logic [NB-1:0] w_wpar;
  logic [NB-1:0] w_old_calc;
  logic [NB-1:0] w_new_calc;
  logic [NB-1:0] w_merged_par;

  assign w_old_par = r_par[w_addr];

  always_comb begin
    w_wpar     = '0;
    w_old_calc = '0;
    w_new_calc = '0;
    for (int i = 0; i < NB; i++) begin
      w_wpar[i]     = even_parity(64'(w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH]));
      w_old_calc[i] = even_parity(64'(w_old[i*BYTE_WIDTH +: BYTE_WIDTH]));
      w_new_calc[i] = even_parity(64'(w_merged[i*BYTE_WIDTH +: BYTE_WIDTH]));
    end
  end

  // Unwritten lanes keep their stored parity so corruption stays visible.
  assign w_merged_par = (w_lane_we & w_wpar) | (~w_lane_we & w_old_par);
  assign w_old_err    = |(w_old_par ^ w_old_calc);
  assign w_new_err    = |(w_merged_par ^ w_new_calc);

  always_ff @(posedge clk) begin
    if (w_wr) r_par[w_addr] <= w_merged_par;
  end
`else
  assign w_old_err = 1'b0;
  assign w_new_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_par_err    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_par_err    <= 1'b0;
      if (w_acc) begin
        if (!we || WRITE_MODE == WM_READ_FIRST) begin
          r_dout       <= w_old;
          r_dout_valid <= 1'b1;
          r_par_err    <= w_old_err;
        end else if (WRITE_MODE == WM_WRITE_FIRST) begin
          r_dout       <= w_merged;
          r_dout_valid <= 1'b1;
          r_par_err    <= w_new_err;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = w_busy;
  assign par_err    = r_par_err;

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: one instance per write mode driven in lockstep and
// compared against a word-array reference model.
module tb_sp_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] din;

  logic [31:0] dout_m  [3];
  logic        valid_m [3];
  logic        busy_m  [3];
  logic        perr_m  [3];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    sp_ram_be #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4),
      .BYTE_WIDTH (8),
      .WRITE_MODE (m),
      .INIT_VALUE (32'h0)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .we         (we),
      .be         (be),
      .addr       (addr),
      .din        (din),
      .dout       (dout_m[m]),
      .dout_valid (valid_m[m]),
      .busy       (busy_m[m]),
      .par_err    (perr_m[m])
    );
  end

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  logic [31:0] ref_mem   [16];
  logic        ref_bad   [16];
  logic [31:0] exp_dout  [3];
  logic        exp_valid [3];
  logic        exp_perr  [3];
  int          init_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s busy m%0d", tag, m), {31'b0, busy_m[m]}, {31'b0, init_left > 0 || !rst_n});
      chk($sformatf("%s dout m%0d", tag, m), dout_m[m], exp_dout[m]);
      chk($sformatf("%s valid m%0d", tag, m), {31'b0, valid_m[m]}, {31'b0, exp_valid[m]});
      chk($sformatf("%s par_err m%0d", tag, m), {31'b0, perr_m[m]}, {31'b0, exp_perr[m]});
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      exp_dout[m]  = '0;
      exp_valid[m] = 1'b0;
      exp_perr[m]  = 1'b0;
    end
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 32'h0;
      ref_bad[a] = 1'b0;
    end
    init_left = 16;
  endtask

  // One clock of stimulus, then the model's view of that edge, then a check.
  task automatic step(input string tag, input logic e, input logic w, input logic [3:0] b,
                      input logic [3:0] a, input logic [31:0] d);
    logic [31:0] old_w;
    logic [31:0] mrg;
    logic        bad;
    @(negedge clk);
    en = e; we = w; be = b; addr = a; din = d;
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      exp_valid[m] = 1'b0;
      exp_perr[m]  = 1'b0;
    end
    if (init_left > 0) begin
      init_left--;
    end else if (e) begin
      old_w = ref_mem[a];
      bad   = ref_bad[a];
      mrg   = old_w;
      for (int i = 0; i < 4; i++)
        if (b[i]) mrg[i*8 +: 8] = d[i*8 +: 8];
      if (!w) begin
        for (int m = 0; m < 3; m++) begin
          exp_dout[m] = old_w; exp_valid[m] = 1'b1; exp_perr[m] = bad;
        end
      end else begin
        ref_mem[a] = mrg;
        ref_bad[a] = bad && !b[0];
        exp_dout[0] = old_w; exp_valid[0] = 1'b1; exp_perr[0] = bad;
        exp_dout[1] = mrg;   exp_valid[1] = 1'b1; exp_perr[1] = bad && !b[0];
      end
    end
    #1 check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("in_reset");

    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++)
      step("sweep_ignore", 1'b1, 1'($urandom), 4'($urandom), 4'($urandom), $urandom);

    for (int a = 0; a < 16; a++) step("init_read", 1'b1, 1'b0, 4'h0, 4'(a), $urandom);
    step("idle", 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

    step("wr_full", 1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
    step("rd_full", 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    chk("rd_full literal", dout_m[0], 32'hDEADBEEF);
    step("wr_lane1", 1'b1, 1'b1, 4'b0010, 4'd3, 32'h00005500);
    step("rd_lane1", 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    chk("rd_lane1 literal", dout_m[0], 32'hDEAD55EF);
    step("wr_mode", 1'b1, 1'b1, 4'hF, 4'd3, 32'h11223344);
    chk("wr_mode m0 literal", dout_m[0], 32'hDEAD55EF);
    chk("wr_mode m1 literal", dout_m[1], 32'h11223344);
    chk("wr_mode m2 literal", dout_m[2], 32'hDEAD55EF);
    step("wr_be0", 1'b1, 1'b1, 4'h0, 4'd3, 32'hFFFFFFFF);
    step("rd_be0", 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);

    step("b2b_wr", 1'b1, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D);
    step("b2b_rd", 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    chk("b2b literal", dout_m[0], 32'hCAFEF00D);

    for (int k = 0; k < 400; k++)
      step("random", ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
           4'($urandom), $urandom);

`ifdef SP_RAM_PARITY_EN
    @(negedge clk);
    g_dut[0].dut.r_mem[7][0] = ~g_dut[0].dut.r_mem[7][0];
    g_dut[1].dut.r_mem[7][0] = ~g_dut[1].dut.r_mem[7][0];
    g_dut[2].dut.r_mem[7][0] = ~g_dut[2].dut.r_mem[7][0];
    ref_mem[7][0] = ~ref_mem[7][0];
    ref_bad[7]    = 1'b1;
    step("par_rd7", 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    step("par_rd6", 1'b1, 1'b0, 4'h0, 4'd6, 32'h0);
`endif

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1 check_all("held_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++)
      step("resweep", 1'b1, 1'b1, 4'hF, 4'($urandom), $urandom);
    for (int a = 0; a < 16; a++) step("reinit_read", 1'b1, 1'b0, 4'h0, 4'(a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
